// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit sequencer: FSM encoding, PRBS9
// geometry and default seeds, plus the single-step PRBS9 update.
package qpsk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } qpsk_state_t;

    localparam int PRBS_W      = 9;
    localparam int PRBS_TAP_HI = 8;
    localparam int PRBS_TAP_LO = 4;

    localparam logic [PRBS_W-1:0] SEED_I_DEF = 9'h1AA;
    localparam logic [PRBS_W-1:0] SEED_Q_DEF = 9'h1FE;

    // x^9 + x^5 + 1, shifting left with the feedback entering at the LSB.
    function automatic logic [PRBS_W-1:0] prbs9_step(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 source with seed load and single-step advance; MSB is the output bit.
module prbs9_gen
    import qpsk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PRBS_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic              msb
);

    logic [PRBS_W-1:0] state_reg;

    // load together with advance leaves the register one step past the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= seed;
        end else if (load) begin
            state_reg <= advance ? prbs9_step(seed) : seed;
        end else if (advance) begin
            state_reg <= prbs9_step(state_reg);
        end
    end

    assign msb = state_reg[PRBS_W-1];

endmodule

// File: rtl/qpsk_tx_seq.sv
// QPSK TX sequencer: filter enable strobe, per-symbol I/Q bits from two PRBS9
// sources, and a start/run/drain FSM that flushes the filter tails.
module qpsk_tx_seq
    import qpsk_pkg::*;
#(
    parameter int                UPSAMPLE      = 4,
    parameter int                CLK_DIV       = 4,
    parameter int                DRAIN_SAMPLES = 24,
    parameter logic [PRBS_W-1:0] SEED_I        = SEED_I_DEF,
    parameter logic [PRBS_W-1:0] SEED_Q        = SEED_Q_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    output logic                        filt_enable,
    output logic                        tx_bit_i,
    output logic                        tx_bit_q,
    output logic [$clog2(UPSAMPLE)-1:0] phase,
    output logic                        busy,
    output logic [15:0]                 sym_count
);

    localparam int PH_W  = $clog2(UPSAMPLE);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DRN_W = $clog2(DRAIN_SAMPLES);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(UPSAMPLE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_SAMPLES - 1);

    qpsk_state_t      state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [PH_W-1:0]  phase_reg;
    logic [DRN_W-1:0] drain_cnt_reg;
    logic             stop_pend_reg;
    logic             filt_enable_reg;
    logic             bit_i_reg;
    logic             bit_q_reg;
    logic             busy_reg;
    logic [15:0]      sym_count_reg;

    logic                   boundary;
    logic                   stop_now;
    logic                   prbs_load;
    logic                   prbs_adv;
    logic [1:0]             prbs_msb;
    logic [1:0][PRBS_W-1:0] seed_vec;

    assign seed_vec[0] = SEED_I;
    assign seed_vec[1] = SEED_Q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_prbs
            prbs9_gen u_prbs (
                .clk     (clk),
                .rst     (rst),
                .seed    (seed_vec[gi]),
                .load    (prbs_load),
                .advance (prbs_adv),
                .msb     (prbs_msb[gi])
            );
        end
    endgenerate

    // The strobe cycle carrying the last enable of a symbol; bits change at its closing edge.
    assign boundary  = filt_enable_reg && (phase_reg == PH_LAST);
    assign stop_now  = stop_pend_reg || stop;
    assign prbs_load = (state_reg == IDLE) && start;
    assign prbs_adv  = prbs_load || ((state_reg == RUN) && boundary && !stop_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= '0;
            phase_reg       <= '0;
            drain_cnt_reg   <= '0;
            stop_pend_reg   <= 1'b0;
            filt_enable_reg <= 1'b0;
            bit_i_reg       <= 1'b0;
            bit_q_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            sym_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    filt_enable_reg <= 1'b0;
                    div_cnt_reg     <= '0;
                    if (start) begin
                        state_reg     <= RUN;
                        bit_i_reg     <= SEED_I[PRBS_W-1];
                        bit_q_reg     <= SEED_Q[PRBS_W-1];
                        sym_count_reg <= 16'd1;
                        phase_reg     <= '0;
                        drain_cnt_reg <= '0;
                        stop_pend_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end

                RUN, DRAIN: begin
                    div_cnt_reg     <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
                    filt_enable_reg <= (div_cnt_reg == DIV_LAST);
                    if (filt_enable_reg) begin
                        phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
                    end

                    if (state_reg == RUN) begin
                        if (stop) begin
                            stop_pend_reg <= 1'b1;
                        end
                        if (boundary) begin
                            if (stop_now) begin
                                // First tail symbol is 1/1; the tail then alternates.
                                state_reg     <= DRAIN;
                                bit_i_reg     <= 1'b1;
                                bit_q_reg     <= 1'b1;
                                stop_pend_reg <= 1'b0;
                                drain_cnt_reg <= '0;
                            end else begin
                                bit_i_reg <= prbs_msb[0];
                                bit_q_reg <= prbs_msb[1];
                                if (sym_count_reg != 16'hFFFF) begin
                                    sym_count_reg <= sym_count_reg + 16'd1;
                                end
                            end
                        end
                    end else if (filt_enable_reg) begin
                        if (drain_cnt_reg == DRN_LAST) begin
                            state_reg       <= IDLE;
                            div_cnt_reg     <= '0;
                            phase_reg       <= '0;
                            drain_cnt_reg   <= '0;
                            filt_enable_reg <= 1'b0;
                            bit_i_reg       <= 1'b0;
                            bit_q_reg       <= 1'b0;
                            busy_reg        <= 1'b0;
                            sym_count_reg   <= '0;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + 1'b1;
                            if (boundary) begin
                                bit_i_reg <= ~bit_i_reg;
                                bit_q_reg <= ~bit_q_reg;
                            end
                        end
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    div_cnt_reg     <= '0;
                    filt_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign filt_enable = filt_enable_reg;
    assign tx_bit_i    = bit_i_reg;
    assign tx_bit_q    = bit_q_reg;
    assign phase       = phase_reg;
    assign busy        = busy_reg;
    assign sym_count   = sym_count_reg;

endmodule

// File: tb/tb_qpsk_tx_seq.sv
// Directed bench for qpsk_tx_seq: first-symbol timing table, long PRBS run
// against a software PRBS9, stop/drain corners and reset during drain.
module tb_qpsk_tx_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        filt_enable;
    logic        tx_bit_i;
    logic        tx_bit_q;
    logic [1:0]  phase;
    logic        busy;
    logic [15:0] sym_count;

    int n_checks = 0;
    int n_fail   = 0;
    int off      = 0;

    qpsk_tx_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .filt_enable (filt_enable),
        .tx_bit_i    (tx_bit_i),
        .tx_bit_q    (tx_bit_q),
        .phase       (phase),
        .busy        (busy),
        .sym_count   (sym_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          off;
        logic        fe;
        logic [1:0]  ph;
        logic        bi;
        logic        bq;
        logic        bz;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        off++;
    endtask

    task automatic wait_off(input int t);
        while (off < t) tick();
    endtask

    function automatic logic [31:0] outs();
        return 32'({filt_enable, phase, tx_bit_i, tx_bit_q, busy, sym_count});
    endfunction

    function automatic logic [8:0] model_step(input logic [8:0] s);
        logic fb;
        fb = s[8] ^ s[4];
        return {s[7:0], fb};
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        off = 0;
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 11; k++) begin
            wait_off(tbl[k].off);
            chk($sformatf("%s vec%0d off%0d", tag, k, tbl[k].off), outs(),
                32'({tbl[k].fe, tbl[k].ph, tbl[k].bi, tbl[k].bq, tbl[k].bz, tbl[k].sc}));
            $display("%s vec%0d off=%0d fe=%0b ph=%0d i=%0b q=%0b busy=%0b sc=%0d",
                     tag, k, off, filt_enable, phase, tx_bit_i, tx_bit_q, busy, sym_count);
        end
    endtask

    // Counts strobes until busy drops; each strobe's bits follow the 1,0,1,... tail.
    task automatic drain_count(input string tag);
        int  n;
        logic b;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (filt_enable) begin
                n++;
                b = (((n - 1) / 4) % 2) == 0;
                chk($sformatf("%s tail bits strobe%0d", tag, n),
                    32'({tx_bit_i, tx_bit_q}), 32'({b, b}));
            end
            if (!busy) break;
        end
        chk($sformatf("%s busy low within bound", tag), 32'(busy), 32'd0);
        chk($sformatf("%s drain strobe count", tag), 32'(n), 32'd24);
        chk($sformatf("%s outputs after drain", tag), outs(), 32'd0);
        $display("%s drain done: strobes=%0d", tag, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] mi;
        logic [8:0] mq;
        logic       last_i;
        logic       last_q;
        int         cnt;

        tbl[0]  = '{0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[1]  = '{3,  1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[2]  = '{4,  1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[3]  = '{5,  1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[4]  = '{8,  1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[5]  = '{12, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[6]  = '{16, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[7]  = '{17, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'd2};
        tbl[8]  = '{20, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'd2};
        tbl[9]  = '{33, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'd3};
        tbl[10] = '{36, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 16'd3};

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick();
        tick();
        chk("reset outputs", outs(), 32'd0);
        rst = 1'b0;

        // Idle with stop pulsed: nothing may move.
        for (int c = 0; c < 50; c++) begin
            stop = (c == 20);
            tick();
            chk($sformatf("idle cycle %0d", c), outs(), 32'd0);
        end
        stop = 1'b0;
        $display("idle: 50 cycles checked");

        do_start();
        run_table("first");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Long run against the software PRBS9.
        mi = 9'h1AA;
        mq = 9'h1FE;
        do_start();
        chk("prbs sym1", 32'({tx_bit_i, tx_bit_q, sym_count}), 32'({mi[8], mq[8], 16'd1}));
        mi = model_step(mi);
        mq = model_step(mq);
        tick();
        last_i = 1'b0;
        last_q = 1'b0;
        for (int k = 2; k <= 600; k++) begin
            repeat (16) tick();
            chk($sformatf("prbs sym%0d", k), 32'({tx_bit_i, tx_bit_q, sym_count}),
                32'({mi[8], mq[8], 16'(k)}));
            last_i = mi[8];
            last_q = mq[8];
            mi = model_step(mi);
            mq = model_step(mq);
        end
        $display("prbs run: 600 symbols checked");

        // Stop mid-symbol at phase 1; symbol 600 must finish with PRBS bits.
        repeat (5) tick();
        chk("stop mid phase", 32'(phase), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("stop mid strobe ph1", 32'({filt_enable, phase, tx_bit_i, tx_bit_q}),
            32'({1'b1, 2'd1, last_i, last_q}));
        repeat (8) tick();
        chk("stop mid strobe ph3", 32'({filt_enable, phase, tx_bit_i, tx_bit_q}),
            32'({1'b1, 2'd3, last_i, last_q}));
        tick();
        chk("stop mid drain entry", outs(),
            32'({1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'd600}));
        drain_count("stopmid");
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (filt_enable || busy) cnt++;
        end
        chk("no activity after drain", 32'(cnt), 32'd0);

        // Stop on a boundary strobe; start during RUN and DRAIN ignored.
        do_start();
        wait_off(22);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in run ignored", 32'({phase, sym_count}), 32'({2'd1, 16'd2}));
        wait_off(32);
        chk("boundary strobe", 32'({filt_enable, phase}), 32'({1'b1, 2'd3}));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop on boundary drain entry", outs(),
            32'({1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 16'd2}));
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start/stop in drain ignored", 32'({tx_bit_i, tx_bit_q, busy, sym_count}),
            32'({1'b1, 1'b1, 1'b1, 16'd2}));
        drain_count("stopbnd");

        // Reset in DRAIN at phase 2, then restart reproduces the first symbols.
        do_start();
        wait_off(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_off(17);
        chk("early stop drain", 32'({tx_bit_i, tx_bit_q, sym_count}), 32'({1'b1, 1'b1, 16'd1}));
        wait_off(26);
        chk("drain phase before rst", 32'({phase, busy}), 32'({2'd2, 1'b1}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst in drain", outs(), 32'd0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (filt_enable || busy) cnt++;
        end
        chk("idle after rst", 32'(cnt), 32'd0);
        do_start();
        run_table("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
